// File: rtl/fixed_point_mac.sv
// fixed_point_mac
// Streaming, pipelined multiply-accumulate over sign-magnitude fixed-point
// operands (Qq_m.q_n plus a sign bit). One (a, b) pair is accepted per cycle.
// Products are accumulated at full internal width. At the packet boundary
// one rounded, saturated sign-magnitude result is emitted.
//
// Ports:
//   clk_i       clock, rising-edge active
//   rst_i       synchronous active-high reset
//   a_in, b_in  operands: bit W-1 is the sign, the rest is the magnitude
//   valid_i     operand pair valid
//   last_i      final pair of the packet (qualified by valid_i)
//   ready_o     block can accept a pair
//   y_out       sign-magnitude dot-product result
//   overflow_o  result was saturated to MAXMAG (qualified by valid_o)
//   valid_o     result valid
//   ready_i     downstream accepts the result
module fixed_point_mac #(
   parameter int q_m   = 16,
   parameter int q_n   = 16,
   parameter int GUARD = 4,
   parameter int ROUND = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [q_m+q_n:0] a_in,
   input  logic [q_m+q_n:0] b_in,
   input  logic             valid_i,
   input  logic             last_i,
   output logic             ready_o,
   output logic [q_m+q_n:0] y_out,
   output logic             overflow_o,
   output logic             valid_o,
   input  logic             ready_i
);

   localparam int M     = q_m + q_n;         // magnitude width
   localparam int PW    = 2 * M;             // raw product magnitude width
   localparam int RW    = 2 * q_m + q_n;     // rescaled product magnitude width
   localparam int ACC_W = 1 + RW + GUARD;

   localparam logic [PW-1:0] RND_ADD = (ROUND != 0) ? (PW'(1) << (q_n - 1)) : PW'(0);

   // Symmetric clamp: the accumulator never holds the most negative code,
   // so its absolute value always fits in ACC_W-1 bits.
   localparam logic signed [ACC_W:0] SAT_POS = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_NEG = -SAT_POS;

   localparam logic [1:0] S_ACCUM = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [ACC_W-1:0] prod_q, prod_d;
   logic             prod_vld_q, prod_last_q;
   logic             fin_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [M:0]       y_q, y_d;
   logic             ovf_q, ovf_d;
   logic             vld_q, vld_d;

   logic             accept;
   logic [PW-1:0]    p_mag, p_rnd;
   logic [RW-1:0]    r_mag;
   logic [ACC_W-1:0] r_ext;
   logic             p_neg;
   logic signed [ACC_W:0] sum;
   logic             acc_neg;
   logic [ACC_W-1:0] acc_abs;
   logic             acc_ovf;

   assign ready_o    = (state_q == S_ACCUM) && !rst_i;
   assign accept     = valid_i && ready_o;
   assign y_out      = y_q;
   assign overflow_o = ovf_q;
   assign valid_o    = vld_q;

   // Product stage: magnitude multiply, optional half-up rounding, rescale.
   // The rounding add cannot carry out of PW bits: (2^M-1)^2 + 2^(q_n-1) < 2^PW.
   assign p_mag = PW'(a_in[M-1:0]) * PW'(b_in[M-1:0]);
   assign p_rnd = p_mag + RND_ADD;
   assign r_mag = p_rnd[PW-1:q_n];
   assign r_ext = {{(ACC_W-RW){1'b0}}, r_mag};
   // A zero magnitude is always positive so negative zero never reaches the sum.
   assign p_neg  = (a_in[M] ^ b_in[M]) && (r_mag != '0);
   assign prod_d = p_neg ? -r_ext : r_ext;

   // One extra bit so the saturation test sees the true sum.
   assign sum = {acc_q[ACC_W-1], acc_q} + {prod_q[ACC_W-1], prod_q};

   assign acc_neg = acc_q[ACC_W-1];
   assign acc_abs = acc_neg ? -acc_q : acc_q;
   assign acc_ovf = |acc_abs[ACC_W-1:M];

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      y_d     = y_q;
      ovf_d   = ovf_q;
      vld_d   = vld_q;

      if (prod_vld_q) begin
         if (sum > SAT_POS)      acc_d = SAT_POS[ACC_W-1:0];
         else if (sum < SAT_NEG) acc_d = SAT_NEG[ACC_W-1:0];
         else                    acc_d = sum[ACC_W-1:0];
      end

      case (state_q)
         S_ACCUM: begin
            if (accept && last_i) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // fin_q marks the edge after the last product was summed.
            if (fin_q) begin
               y_d     = {acc_neg, acc_ovf ? {M{1'b1}} : acc_abs[M-1:0]};
               ovf_d   = acc_ovf;
               vld_d   = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (ready_i) begin
               vld_d   = 1'b0;
               acc_d   = '0;
               state_d = S_ACCUM;
            end
         end
         default: state_d = S_ACCUM;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_ACCUM;
         prod_q      <= '0;
         prod_vld_q  <= 1'b0;
         prod_last_q <= 1'b0;
         fin_q       <= 1'b0;
         acc_q       <= '0;
         y_q         <= '0;
         ovf_q       <= 1'b0;
         vld_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         prod_q      <= prod_d;
         prod_vld_q  <= accept;
         prod_last_q <= accept && last_i;
         fin_q       <= prod_vld_q && prod_last_q;
         acc_q       <= acc_d;
         y_q         <= y_d;
         ovf_q       <= ovf_d;
         vld_q       <= vld_d;
      end
   end

endmodule

// File: tb/tb_fixed_point_mac.sv
// Directed bench for fixed_point_mac (Q16.16). Two instances share the
// stimulus: dut0 truncates (ROUND=0), dut1 rounds half-up (ROUND=1).
module tb_fixed_point_mac;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [32:0] a_in, b_in;
   logic        valid_i, last_i, ready_i;
   logic        ready0, ovf0, vld0;
   logic [32:0] y0;
   logic        ready1, ovf1, vld1;
   logic [32:0] y1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fixed_point_mac #(.q_m(16), .q_n(16), .GUARD(4), .ROUND(0)) dut0 (
      .clk_i(clk), .rst_i(rst_i), .a_in(a_in), .b_in(b_in),
      .valid_i(valid_i), .last_i(last_i), .ready_o(ready0),
      .y_out(y0), .overflow_o(ovf0), .valid_o(vld0), .ready_i(ready_i)
   );

   fixed_point_mac #(.q_m(16), .q_n(16), .GUARD(4), .ROUND(1)) dut1 (
      .clk_i(clk), .rst_i(rst_i), .a_in(a_in), .b_in(b_in),
      .valid_i(valid_i), .last_i(last_i), .ready_o(ready1),
      .y_out(y1), .overflow_o(ovf1), .valid_o(vld1), .ready_i(ready_i)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one pair and hold it until accepted (bounded).
   task automatic beat(input logic [32:0] a, input logic [32:0] b, input logic last);
      int n = 0;
      a_in = a; b_in = b; last_i = last; valid_i = 1'b1;
      while (!ready0 && n < 20) begin
         step();
         n++;
      end
      check("beat_ready", 64'(ready0), 64'd1);
      step();
      valid_i = 1'b0;
      last_i  = 1'b0;
   endtask

   // Called just after the edge that accepted the last beat (edge k).
   task automatic expect_result(input string tag, input logic [32:0] ey0,
                                input logic eo, input logic [32:0] ey1);
      check({tag, "_vld_k"}, 64'(vld0), 64'd0);
      step();
      check({tag, "_vld_k1"}, 64'(vld0), 64'd0);
      step();
      check({tag, "_vld_k2"}, 64'(vld0), 64'd1);
      check({tag, "_y0"}, 64'(y0), 64'(ey0));
      check({tag, "_ovf0"}, 64'(ovf0), 64'(eo));
      check({tag, "_vld1"}, 64'(vld1), 64'd1);
      check({tag, "_y1"}, 64'(y1), 64'(ey1));
   endtask

   task automatic handshake(input string tag);
      ready_i = 1'b1;
      step();
      ready_i = 1'b0;
      check({tag, "_vld_drop"}, 64'(vld0), 64'd0);
      check({tag, "_ready_back"}, 64'(ready0), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; a_in = '0; b_in = '0; valid_i = 1'b0; last_i = 1'b0; ready_i = 1'b0;

      // Reset state
      step(); step();
      check("rst_ready_low", 64'(ready0), 64'd0);
      check("rst_y", 64'(y0), 64'd0);
      check("rst_ovf", 64'(ovf0), 64'd0);
      check("rst_vld", 64'(vld0), 64'd0);
      rst_i = 1'b0;
      #1;
      check("rst_ready_high", 64'(ready0), 64'd1);

      // Single beat 0.5 * 0.5 = 0.25
      beat(33'h0_0000_8000, 33'h0_0000_8000, 1'b1);
      expect_result("half_sq", 33'h0_0000_4000, 1'b0, 33'h0_0000_4000);
      handshake("half_sq");

      // Both signs negative gives the same positive result
      beat(33'h1_0000_8000, 33'h1_0000_8000, 1'b1);
      expect_result("half_sq_neg", 33'h0_0000_4000, 1'b0, 33'h0_0000_4000);
      handshake("half_sq_neg");

      // [1.5, 0.5] . [1.5, -0.5] = 2.25 - 0.25 = 2.0, back-to-back beats
      beat(33'h0_0001_8000, 33'h0_0001_8000, 1'b0);
      beat(33'h0_0000_8000, 33'h1_0000_8000, 1'b1);
      expect_result("two_beat", 33'h0_0002_0000, 1'b0, 33'h0_0002_0000);
      handshake("two_beat");

      // [-1.5] . [1.5] = -2.25
      beat(33'h1_0001_8000, 33'h0_0001_8000, 1'b1);
      expect_result("neg_225", 33'h1_0002_4000, 1'b0, 33'h1_0002_4000);
      handshake("neg_225");

      // Saturation: 65535 * 2 exceeds MAXMAG
      beat(33'h0_FFFF_0000, 33'h0_0002_0000, 1'b1);
      expect_result("sat_pos", 33'h0_FFFF_FFFF, 1'b1, 33'h0_FFFF_FFFF);
      handshake("sat_pos");

      beat(33'h1_FFFF_0000, 33'h0_0002_0000, 1'b1);
      expect_result("sat_neg", 33'h1_FFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
      handshake("sat_neg");

      // Rounding: 2^-16 * 0.5 truncates to 0, rounds to 2^-16
      beat(33'h0_0000_0001, 33'h0_0000_8000, 1'b1);
      expect_result("rnd_half", 33'h0_0000_0000, 1'b0, 33'h0_0000_0001);
      handshake("rnd_half");

      // Negative product truncated to zero must come out as +0
      beat(33'h1_0000_0001, 33'h0_0000_8000, 1'b1);
      expect_result("neg_zero", 33'h0_0000_0000, 1'b0, 33'h1_0000_0001);
      handshake("neg_zero");

      // 0x1F98^2 = 0x3E6_2A40 -> fraction below one half, same in both modes
      beat(33'h0_0000_1F98, 33'h0_0000_1F98, 1'b1);
      expect_result("rnd_same", 33'h0_0000_03E6, 1'b0, 33'h0_0000_03E6);

      // Backpressure: result held, no beats absorbed while valid_i stays high
      a_in = 33'h0_0001_0000; b_in = 33'h0_0001_0000; valid_i = 1'b1; last_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_y_stable", 64'(y0), 64'h3E6);
         check("bp_vld_stable", 64'(vld0), 64'd1);
         check("bp_ready_low", 64'(ready0), 64'd0);
      end
      valid_i = 1'b0; last_i = 1'b0;
      handshake("bp");

      // Next packet must start from zero
      beat(33'h0_0000_8000, 33'h0_0000_8000, 1'b1);
      expect_result("after_bp", 33'h0_0000_4000, 1'b0, 33'h0_0000_4000);
      handshake("after_bp");

      // Reset mid-packet after 2 of 4 beats (each 2.0 * 2.0)
      beat(33'h0_0002_0000, 33'h0_0002_0000, 1'b0);
      beat(33'h0_0002_0000, 33'h0_0002_0000, 1'b0);
      rst_i = 1'b1;
      #1;
      check("midrst_ready_low", 64'(ready0), 64'd0);
      step();
      check("midrst_y", 64'(y0), 64'd0);
      check("midrst_ovf", 64'(ovf0), 64'd0);
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("midrst_no_vld", 64'(vld0), 64'd0);
         step();
      end

      // Fresh single beat 1.0 * 1.0
      beat(33'h0_0001_0000, 33'h0_0001_0000, 1'b1);
      expect_result("post_rst", 33'h0_0001_0000, 1'b0, 33'h0_0001_0000);
      handshake("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
